// File: rtl/vga_timing_pattern_v1.sv
// vga_timing_pattern_v1: VGA/DVI raster timing generator with a built-in test
// pattern source (colour bars, grid, solid colour, gradient).
// Stage p0 holds the raster counters. Stage p1 is the registered output set,
// which trails the counters by one pixel clock.
// Optional feature: define VGA_PATTERN_SCROLL_EN to make the colour bars
// scroll horizontally by SCROLL_STEP pixels per frame.
module vga_timing_pattern_v1 #(
  parameter int H_SYNC      = 208,
  parameter int H_BP        = 344,
  parameter int H_ACT       = 1920,
  parameter int H_FP        = 136,
  parameter int V_SYNC      = 5,
  parameter int V_BP        = 42,
  parameter int V_ACT       = 1080,
  parameter int V_FP        = 3,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int CNT_W       = 12,
  parameter int GRID_LOG2   = 6,
  parameter int SCROLL_STEP = 4
) (
  input  logic             CLK_PIX_i,
  input  logic             RST_i,
  input  logic [1:0]       MODE_i,
  input  logic [23:0]      COLOR_i,
  output logic             HS_o,
  output logic             VS_o,
  output logic             VGA_BLANK,
  output logic             VGA_SYNC,
  output logic             DE_o,
  output logic             FRAME_START_o,
  output logic [CNT_W-1:0] X_POS_o,
  output logic [CNT_W-1:0] Y_POS_o,
  output logic [7:0]       RGB_R_o,
  output logic [7:0]       RGB_G_o,
  output logic [7:0]       RGB_B_o
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int BAR_W   = H_ACT / 8;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] HA_START  = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] HA_END    = CNT_W'(H_SYNC + H_BP + H_ACT);
  localparam logic [CNT_W-1:0] VA_START  = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] VA_END    = CNT_W'(V_SYNC + V_BP + V_ACT);
  localparam logic [CNT_W-1:0] BARS_END  = CNT_W'(8 * BAR_W);
  localparam logic [CNT_W-1:0] GRID_MASK = CNT_W'((1 << GRID_LOG2) - 1);

  // Eight-bar palette: green, blue, black, cyan, red, purple, yellow, white.
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'h00FF00;
      3'd1:    c = 24'h0000FF;
      3'd2:    c = 24'h000000;
      3'd3:    c = 24'h00FFFF;
      3'd4:    c = 24'hFF0000;
      3'd5:    c = 24'hFF00FF;
      3'd6:    c = 24'hFFFF00;
      default: c = 24'hFFFFFF;
    endcase
    return c;
  endfunction

  logic [CNT_W-1:0] x_cnt_p0;
  logic [CNT_W-1:0] y_cnt_p0;
  logic [1:0]       mode_lat;
  logic [23:0]      color_lat;

  logic             frame_last;
  logic             x_act;
  logic             y_act;
  logic             de_c;
  logic [CNT_W-1:0] ax;
  logic [CNT_W-1:0] ay;
  logic [CNT_W-1:0] bar_x;
  logic [2:0]       bar_idx;
  logic             grid_on;
  logic [23:0]      pix;

  // ---- stage p0: raster counters ----

  // Pixel and line counters; line advances when the pixel counter wraps.
  always_ff @(posedge CLK_PIX_i or negedge RST_i) begin
    if (!RST_i) begin
      x_cnt_p0 <= '0;
      y_cnt_p0 <= '0;
    end else if (x_cnt_p0 == H_LAST) begin
      x_cnt_p0 <= '0;
      if (y_cnt_p0 == V_LAST) y_cnt_p0 <= '0;
      else                    y_cnt_p0 <= y_cnt_p0 + 1'b1;
    end else begin
      x_cnt_p0 <= x_cnt_p0 + 1'b1;
    end
  end

  // Pattern controls are sampled only on the final pixel of a frame so a
  // frame is never drawn with mixed settings.
  always_ff @(posedge CLK_PIX_i or negedge RST_i) begin
    if (!RST_i) begin
      mode_lat  <= 2'd0;
      color_lat <= 24'h000000;
    end else if (frame_last) begin
      mode_lat  <= MODE_i;
      color_lat <= COLOR_i;
    end
  end

`ifdef VGA_PATTERN_SCROLL_EN
  localparam logic [CNT_W-1:0] H_ACT_W = CNT_W'(H_ACT);

  logic [CNT_W-1:0] scroll_ofs;
  logic [CNT_W-1:0] ofs_next;
  logic [CNT_W-1:0] bar_sum;

  // Next scroll offset, kept in [0, H_ACT).
  always_comb begin
    ofs_next = scroll_ofs + CNT_W'(SCROLL_STEP);
    if (ofs_next >= H_ACT_W) ofs_next = ofs_next - H_ACT_W;
  end

  // Scroll offset advances once per frame, at the frame boundary.
  always_ff @(posedge CLK_PIX_i or negedge RST_i) begin
    if (!RST_i)          scroll_ofs <= '0;
    else if (frame_last) scroll_ofs <= ofs_next;
  end

  // Bar lookup column: active x shifted by the offset, wrapped at H_ACT.
  always_comb begin
    bar_sum = ax + scroll_ofs;
    bar_x   = bar_sum;
    if (bar_sum >= H_ACT_W) bar_x = bar_sum - H_ACT_W;
  end
`else
  // Static bars: the lookup column is the active x itself.
  always_comb begin
    bar_x = ax;
  end
`endif

  // Region decode, active coordinates and pattern selection for this pixel.
  always_comb begin
    frame_last = (x_cnt_p0 == H_LAST) && (y_cnt_p0 == V_LAST);
    x_act      = (x_cnt_p0 >= HA_START) && (x_cnt_p0 < HA_END);
    y_act      = (y_cnt_p0 >= VA_START) && (y_cnt_p0 < VA_END);
    de_c       = x_act && y_act;
    ax         = de_c ? (x_cnt_p0 - HA_START) : '0;
    ay         = de_c ? (y_cnt_p0 - VA_START) : '0;

    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (bar_x >= CNT_W'(i * BAR_W)) bar_idx = 3'(i);
    end

    grid_on = ((ax & GRID_MASK) == '0) || ((ay & GRID_MASK) == '0);

    case (mode_lat)
      2'd0:    pix = (bar_x >= BARS_END) ? 24'hFFFFFF : bar_color(bar_idx);
      2'd1:    pix = grid_on ? 24'hFFFFFF : 24'h000000;
      2'd2:    pix = color_lat;
      default: pix = {ax[7:0], ay[7:0], ax[7:0] ^ ay[7:0]};
    endcase

    if (!de_c) pix = 24'h000000;
  end

  // ---- stage p1: registered outputs ----

  // Every output is registered from the same counter state so they stay aligned.
  always_ff @(posedge CLK_PIX_i or negedge RST_i) begin
    if (!RST_i) begin
      HS_o          <= ~HS_POL;
      VS_o          <= ~VS_POL;
      DE_o          <= 1'b0;
      VGA_BLANK     <= 1'b0;
      FRAME_START_o <= 1'b0;
      X_POS_o       <= '0;
      Y_POS_o       <= '0;
      RGB_R_o       <= 8'h00;
      RGB_G_o       <= 8'h00;
      RGB_B_o       <= 8'h00;
    end else begin
      HS_o          <= (x_cnt_p0 < HS_END) ? HS_POL : ~HS_POL;
      VS_o          <= (y_cnt_p0 < VS_END) ? VS_POL : ~VS_POL;
      DE_o          <= de_c;
      VGA_BLANK     <= de_c;
      FRAME_START_o <= (x_cnt_p0 == '0) && (y_cnt_p0 == '0);
      X_POS_o       <= ax;
      Y_POS_o       <= ay;
      RGB_R_o       <= pix[23:16];
      RGB_G_o       <= pix[15:8];
      RGB_B_o       <= pix[7:0];
    end
  end

  // Composite sync is unused on this interface.
  assign VGA_SYNC = 1'b0;

endmodule
